clk_divider_prog: RTL

//  Runtime-programmable integer clock divider; successor to the fixed divide-by-2 toggle divider.

---
 rtl/clk_divider_prog.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clk_divider_prog.sv
// clk_divider_prog -- runtime-programmable integer clock divider.
//
// Divides system_clk by N (N = active_div, N >= 2) and produces a registered
// divided clock (clk_out) plus a one-cycle strobe (tick) marking the first
// high cycle of every period. A new divisor is offered over a valid/ready
// handshake, parked in a pending register, and only becomes active on the
// edge where the current period wraps. A period is therefore never cut
// short or stretched.
//
// Optional build macro: CLK_DIV_PERIOD_CNT_EN
//   When defined, the output period_cnt[31:0] is added. It counts completed
//   periods (wrap edges) and rolls over from 2^32-1 to 0.
//   When undefined, the port and its counter are absent. All other
//   behaviour is unchanged.

module clk_divider_prog #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2     // must be >= 2
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] active_div
`ifdef CLK_DIV_PERIOD_CNT_EN
    ,
    output logic [31:0]      period_cnt
`endif
);

    localparam logic [DIV_W-1:0] DEFAULT_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_N     = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    // Handshake state. ST_PENDING means a divisor is parked and waiting for
    // the next period boundary. div_ready is simply "not pending".
    typedef enum logic {
        ST_READY   = 1'b0,
        ST_PENDING = 1'b1
    } hs_state_t;

    hs_state_t        state_reg,   state_next;
    logic [DIV_W-1:0] pending_reg, pending_next;
    logic [DIV_W-1:0] active_reg,  active_next;
    logic [DIV_W-1:0] cnt_reg,     cnt_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg,    tick_next;

    logic [DIV_W-1:0] last_cnt;    // N-1, the final count of a period
    logic [DIV_W-1:0] half_len;    // L = ceil(N/2), the first high count
    logic [DIV_W-1:0] clamped_div; // requested divisor with the floor of 2 applied
    logic             wrap;        // this edge ends the current period

    // Decode the period boundary and the low/high split of the active divisor.
    always_comb begin
        last_cnt    = active_reg - ONE;
        half_len    = (active_reg >> 1) + {{(DIV_W-1){1'b0}}, active_reg[0]};
        clamped_div = (div_in < MIN_N) ? MIN_N : div_in;
        wrap        = en && (cnt_reg == last_cnt);
    end

    // Handshake FSM: accept into pending, promote pending to active on wrap.
    // Accepting requires ST_READY and promoting requires ST_PENDING, so a
    // load on the wrap edge itself lands in pending. It then applies at the
    // following wrap.
    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        active_next  = active_reg;
        case (state_reg)
            ST_READY: begin
                if (div_valid) begin
                    pending_next = clamped_div;
                    state_next   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (wrap) begin
                    active_next = pending_reg;
                    state_next  = ST_READY;
                end
            end
            default: begin
                state_next = ST_READY;
            end
        endcase
    end

    // Period counter, plus clk_out/tick computed from the count that will be
    // held after this edge. Both outputs are therefore registers with no
    // combinational path from cnt_reg. On a wrap the next count is 0, and 0
    // is always below L (L >= 1), so using the current L is safe even when
    // the divisor is switching on that edge.
    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            cnt_next = wrap ? '0 : cnt_reg + ONE;
        end
        clk_out_next = (cnt_next >= half_len);
        tick_next    = en && (cnt_next == half_len);
    end

    // State registers. The synchronous reset takes priority over en,
    // div_valid and any pending load.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state_reg   <= ST_READY;
            pending_reg <= DEFAULT_N;
            active_reg  <= DEFAULT_N;
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            active_reg  <= active_next;
            cnt_reg     <= cnt_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
        end
    end

    assign div_ready  = (state_reg == ST_READY);
    assign clk_out    = clk_out_reg;
    assign tick       = tick_reg;
    assign active_div = active_reg;

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [31:0] period_cnt_reg;

    // Count completed periods. wrap already requires en, so the count holds
    // while the divider is frozen.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            period_cnt_reg <= '0;
        end else if (wrap) begin
            period_cnt_reg <= period_cnt_reg + 32'd1;
        end
    end

    assign period_cnt = period_cnt_reg;
`endif

endmodule
